alu_sched: RTL and testbench
============================

# alu_sched

Two-requester scheduler for the shared ALU datapath of the SHA processor. It takes operation requests from two clients, for example the message-schedule unit and the round-compression unit. It arbitrates round-robin and sequences one operation at a time through a single combinational ALU core. Each result is returned with its flags, a requester tag and an error bit over a valid/ready response channel.

## Interface
- N, 32, operand/result width in bits (power of two, ≥ 8)
- CNT_W, 16, width of the completed-operation counter
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req0_valid / req1_valid  in  1  request present from client 0 / client 1
- req0_ready / req1_ready  out  1  scheduler accepts the request this cycle
- req0_a, req0_b / req1_a, req1_b  in  N  operands
- req0_op / req1_op  in  4  opcode
- rsp_valid  out  1  response held valid
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  1  requester that issued the operation
- rsp_result  out  N  ALU result
- rsp_z  out  1  result == 0
- rsp_n  out  1  result[N-1]
- rsp_err  out  1  opcode was illegal
- op_count  out  CNT_W  completed responses, wraps modulo 2^CNT_W

## Operation
- Opcodes:
  - 0 ADD, 1 SUB (a−b), 2 AND, 3 OR, 4 XOR.
  - 5 SRL, 6 SRA, 7 SLL, 8 ROR (rotate right).
  - 9–15 are illegal.
- Shift/rotate amount is b[$clog2(N)-1:0]; upper bits of b are ignored.
- ADD/SUB wrap modulo 2^N; carry/overflow are not reported.
- Illegal op: result 0, z=1, n=0, err=1. It still completes a full transaction and is counted.
- FSM states:
  - IDLE: reqX_ready is asserted only for the granted requester.
  - EXEC: the ALU evaluates the registered operands; the result and flags are registered.
  - RESP: rsp_* are held stable until the rsp_valid & rsp_ready handshake.
- Transitions:
  - IDLE→EXEC on a request handshake.
  - EXEC→RESP unconditionally.
  - RESP→IDLE on the response handshake.
- Grant:
  - If only one valid is present, that requester is granted.
  - If both are valid, the requester not served last is granted.
  - The last-served pointer updates on acceptance only.
- Both ready outputs are 0 outside IDLE. Requesters must hold a, b and op stable while valid and not ready.
- op_count increments on each response handshake, wrapping from 2^CNT_W−1 to 0.

## Timing
- Reset values:
  - State IDLE; last-served pointer = 1, so client 0 wins the first tie.
  - rsp_valid=0, rsp_id=0, rsp_result=0, rsp_z=0, rsp_n=0, rsp_err=0, op_count=0.
  - req0_ready/req1_ready follow the IDLE grant logic combinationally once rst is low.
- Latency: a request accepted in cycle t gives rsp_valid=1 in cycle t+2.
- With rsp_ready held high, the response handshake is in cycle t+2 and the next acceptance is possible in cycle t+3. Peak throughput is one op per 3 cycles.
- Backpressure: rsp_ready low holds RESP indefinitely with all rsp_* stable. No new request is accepted during this time.
- Simultaneous requests in IDLE: exactly one ready is high in that cycle; the other requester waits.
- Reset asserted mid-operation: the in-flight operation is discarded without a response or count, and outputs return to their reset values immediately (asynchronously).
- No combinational path from rsp_ready to req*_ready.

## Structure
- Shared package alu_pkg:
  - alu_op_e: 4-bit opcode enum.
  - sched_state_e: IDLE/EXEC/RESP.
  - OP_LAST_LEGAL constant = 8.
- Sub-module alu_core, combinational:
  - Inputs a, b, op; outputs result, z, n, err.
  - Instantiated once.
  - The same alu_core is reusable by the rest of the datapath.
- The scheduler holds the FSM, round-robin pointer, operand/result registers and op_count.

## Test plan
- Reset, then client 0 only: ADD a=0xFFFFFFFF, b=1 accepted cycle 0 → cycle 2: rsp_valid=1, id=0, result=0, z=1, n=0, err=0; op_count=1 after handshake.
- Both clients valid continuously, rsp_ready=1:
  - Client 0 (SUB 5−7) is served first, giving 0xFFFFFFFE, n=1.
  - Client 1 (ROR 0x1, b=1) follows, giving 0x80000000, n=1.
  - Grants alternate 0,1,0,1 for 8 ops.
- Shift edges:
  - SRA 0x80000000 by b=0x21 (amount 1) → 0xC0000000.
  - SRL same → 0x40000000.
  - SLL 0x1 by 31 → 0x80000000.
- Illegal op 12 from client 1 → result 0, z=1, err=1, id=1; op_count increments.
- rsp_ready low 10 cycles with both requests pending → rsp_* stable, both ready=0; the handshake then releases the next grant.
- rst asserted during EXEC → rsp_valid stays 0, op_count unchanged; the next request after reset behaves as the first test.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the SHA ALU datapath: opcode encoding and scheduler states.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_SRL = 4'd5,
        OP_SRA = 4'd6,
        OP_SLL = 4'd7,
        OP_ROR = 4'd8
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } sched_state_e;

    localparam logic [3:0] OP_LAST_LEGAL = 4'd8;

endpackage

// File: rtl/alu_sched_if.sv
// Request/response bundle between the two ALU clients, the consumer and alu_sched.
interface alu_sched_if #(parameter int N = 32);

    logic         req0_valid;
    logic         req0_ready;
    logic [N-1:0] req0_a;
    logic [N-1:0] req0_b;
    logic [3:0]   req0_op;

    logic         req1_valid;
    logic         req1_ready;
    logic [N-1:0] req1_a;
    logic [N-1:0] req1_b;
    logic [3:0]   req1_op;

    logic         rsp_valid;
    logic         rsp_ready;
    logic         rsp_id;
    logic [N-1:0] rsp_result;
    logic         rsp_z;
    logic         rsp_n;
    logic         rsp_err;

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_result, rsp_z, rsp_n, rsp_err
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_result, rsp_z, rsp_n, rsp_err
    );

endinterface

// File: rtl/alu_core.sv
// Combinational ALU: arithmetic, logic, shifts and rotate-right with zero/negative/illegal flags.
module alu_core
    import alu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [3:0]   op,
    output logic [N-1:0] result,
    output logic         z,
    output logic         n,
    output logic         err
);

    localparam int SH_W = $clog2(N);

    logic [SH_W-1:0] amt;
    logic [SH_W-1:0] amt_neg;

    // Only the low log2(N) bits of b form the shift amount; -amt mod N drives the rotate's left half.
    assign amt     = b[SH_W-1:0];
    assign amt_neg = SH_W'(0) - amt;

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        result = '0;
        case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_SRL:  result = a >> amt;
            OP_SRA:  result = N'($signed(a) >>> amt);
            OP_SLL:  result = a << amt;
            OP_ROR:  result = (a >> amt) | (a << amt_neg);
            default: result = '0;
        endcase
    end

    assign err = (op > OP_LAST_LEGAL);
    assign z   = (result == '0);
    assign n   = result[N-1];

endmodule

// File: rtl/alu_sched.sv
// Round-robin scheduler feeding two requesters through one shared alu_core, one op at a time.
module alu_sched
    import alu_pkg::*;
#(
    parameter int N     = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    alu_sched_if.slave       bus,
    output logic [CNT_W-1:0] op_count
);

    sched_state_e state_q, state_d;

    logic             last_q;
    logic [N-1:0]     a_q, b_q;
    logic [3:0]       op_q;
    logic             any_valid, grant_id, accept, rsp_hs;
    logic [N-1:0]     core_result;
    logic             core_z, core_n, core_err;
    logic             id_q, z_q, n_q, err_q;
    logic [N-1:0]     result_q;
    logic [CNT_W-1:0] count_q;

    // On a tie the requester not served last wins; otherwise whichever one is valid.
    assign any_valid = bus.req0_valid | bus.req1_valid;
    assign grant_id  = (bus.req0_valid && bus.req1_valid) ? ~last_q : bus.req1_valid;
    assign accept    = (state_q == IDLE) && any_valid;
    assign rsp_hs    = (state_q == RESP) && bus.rsp_ready;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_valid) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.req0_ready = accept && !grant_id;
        bus.req1_ready = accept &&  grant_id;
        bus.rsp_valid  = (state_q == RESP);
    end

    alu_core #(.N(N)) u_core (
        .a      (a_q),
        .b      (b_q),
        .op     (op_q),
        .result (core_result),
        .z      (core_z),
        .n      (core_n),
        .err    (core_err)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q   <= 1'b1;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            id_q     <= 1'b0;
            result_q <= '0;
            z_q      <= 1'b0;
            n_q      <= 1'b0;
            err_q    <= 1'b0;
            count_q  <= '0;
        end else begin
            if (accept) begin
                last_q <= grant_id;
                a_q    <= grant_id ? bus.req1_a  : bus.req0_a;
                b_q    <= grant_id ? bus.req1_b  : bus.req0_b;
                op_q   <= grant_id ? bus.req1_op : bus.req0_op;
            end
            // last_q already names the in-flight requester once the op has been accepted.
            if (state_q == EXEC) begin
                id_q     <= last_q;
                result_q <= core_result;
                z_q      <= core_z;
                n_q      <= core_n;
                err_q    <= core_err;
            end
            if (rsp_hs) count_q <= count_q + CNT_W'(1);
        end
    end

    assign bus.rsp_id     = id_q;
    assign bus.rsp_result = result_q;
    assign bus.rsp_z      = z_q;
    assign bus.rsp_n      = n_q;
    assign bus.rsp_err    = err_q;
    assign op_count       = count_q;

endmodule

// File: tb/tb_alu_sched.sv
// Directed bench for alu_sched: single ops, round-robin ties, shift edges, illegal op, backpressure, reset.
module tb_alu_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] op_count;
    int          tests = 0;
    int          failed = 0;
    int          exp_count = 0;

    alu_sched_if #(.N(32)) bus ();

    alu_sched #(.N(32), .CNT_W(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .op_count (op_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic check_rsp(input string tag, input logic id, input logic [31:0] res,
                             input logic z, input logic n, input logic err);
        check({tag, " valid"},  32'(bus.rsp_valid), 32'd1);
        check({tag, " id"},     32'(bus.rsp_id),    32'(id));
        check({tag, " result"}, bus.rsp_result,     res);
        check({tag, " z"},      32'(bus.rsp_z),     32'(z));
        check({tag, " n"},      32'(bus.rsp_n),     32'(n));
        check({tag, " err"},    32'(bus.rsp_err),   32'(err));
    endtask

    // One complete transaction from a single client with the consumer always ready.
    task automatic run_single(input logic id, input logic [31:0] a, input logic [31:0] b,
                              input logic [3:0] op, input logic [31:0] res,
                              input logic z, input logic n, input logic err, input string tag);
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        if (!id) begin
            bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
            bus.req1_valid = 1'b0;
        end else begin
            bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
            bus.req0_valid = 1'b0;
        end
        #1;
        check({tag, " ready"}, 32'(id ? bus.req1_ready : bus.req0_ready), 32'd1);
        check({tag, " other ready"}, 32'(id ? bus.req0_ready : bus.req1_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        #1;
        check({tag, " exec no valid"}, 32'(bus.rsp_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check_rsp(tag, id, res, z, n, err);
        @(posedge clk);
        @(negedge clk);
        exp_count++;
        check({tag, " valid dropped"}, 32'(bus.rsp_valid), 32'd0);
        check({tag, " op_count"}, 32'(op_count), 32'(exp_count));
    endtask

    initial begin
        bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = '0;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = '0;
        bus.rsp_ready  = 1'b0;

        // Reset state
        #2;
        check("reset rsp_valid",  32'(bus.rsp_valid),  32'd0);
        check("reset rsp_id",     32'(bus.rsp_id),     32'd0);
        check("reset rsp_result", bus.rsp_result,      32'd0);
        check("reset rsp_z",      32'(bus.rsp_z),      32'd0);
        check("reset rsp_n",      32'(bus.rsp_n),      32'd0);
        check("reset rsp_err",    32'(bus.rsp_err),    32'd0);
        check("reset op_count",   32'(op_count),       32'd0);
        check("reset ready0",     32'(bus.req0_ready), 32'd0);
        check("reset ready1",     32'(bus.req1_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Client 0 ADD wraps to zero
        run_single(1'b0, 32'hFFFF_FFFF, 32'h1, 4'd0, 32'h0, 1'b1, 1'b0, 1'b0, "add wrap");

        // Fresh reset so client 0 wins the first tie
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst2 op_count", 32'(op_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_count = 0;

        // Both clients valid continuously: grants alternate 0,1,0,1...
        bus.rsp_ready = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_a = 32'd5; bus.req0_b = 32'd7; bus.req0_op = 4'd1;
        bus.req1_valid = 1'b1; bus.req1_a = 32'd1; bus.req1_b = 32'd1; bus.req1_op = 4'd8;
        for (int i = 0; i < 8; i++) begin
            #1;
            check("rr ready0", 32'(bus.req0_ready), 32'((i % 2) == 0));
            check("rr ready1", 32'(bus.req1_ready), 32'((i % 2) == 1));
            @(posedge clk);
            @(negedge clk);
            check("rr exec ready0", 32'(bus.req0_ready), 32'd0);
            check("rr exec ready1", 32'(bus.req1_ready), 32'd0);
            @(posedge clk);
            @(negedge clk);
            if ((i % 2) == 0) check_rsp("rr sub", 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0);
            else              check_rsp("rr ror", 1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
            @(posedge clk);
            @(negedge clk);
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        exp_count = 8;
        check("rr op_count", 32'(op_count), 32'd8);

        // Shift edges and a plain OR
        run_single(1'b0, 32'h8000_0000, 32'h21, 4'd6, 32'hC000_0000, 1'b0, 1'b1, 1'b0, "sra");
        run_single(1'b0, 32'h8000_0000, 32'h21, 4'd5, 32'h4000_0000, 1'b0, 1'b0, 1'b0, "srl");
        run_single(1'b0, 32'h1,         32'd31, 4'd7, 32'h8000_0000, 1'b0, 1'b1, 1'b0, "sll");
        run_single(1'b0, 32'hA0,        32'h0B, 4'd3, 32'hAB,        1'b0, 1'b0, 1'b0, "or");

        // Illegal opcode from client 1
        run_single(1'b1, 32'h1234_5678, 32'h9, 4'd12, 32'h0, 1'b1, 1'b0, 1'b1, "illegal");

        // Backpressure: last served is client 1, so client 0 wins the tie
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_a = 32'd2;      bus.req0_b = 32'd3;      bus.req0_op = 4'd0;
        bus.req1_valid = 1'b1; bus.req1_a = 32'hF0F0;   bus.req1_b = 32'hFF00;   bus.req1_op = 4'd2;
        #1;
        check("bp grant0 ready0", 32'(bus.req0_ready), 32'd1);
        check("bp grant0 ready1", 32'(bus.req1_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("bp exec valid", 32'(bus.rsp_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            check_rsp("bp hold", 1'b0, 32'd5, 1'b0, 1'b0, 1'b0);
            check("bp hold ready0", 32'(bus.req0_ready), 32'd0);
            check("bp hold ready1", 32'(bus.req1_ready), 32'd0);
            check("bp hold op_count", 32'(op_count), 32'(exp_count));
            @(posedge clk);
            @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        exp_count++;
        check("bp release op_count", 32'(op_count), 32'(exp_count));
        check("bp release ready0", 32'(bus.req0_ready), 32'd0);
        check("bp release ready1", 32'(bus.req1_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_rsp("bp and", 1'b1, 32'hF000, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        exp_count++;
        check("bp and op_count", 32'(op_count), 32'(exp_count));

        // Reset during EXEC discards the op and clears outputs asynchronously
        bus.req0_valid = 1'b1; bus.req0_a = 32'd7; bus.req0_b = 32'd8; bus.req0_op = 4'd0;
        @(posedge clk);
        @(negedge clk);
        bus.req0_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("mid rst rsp_valid",  32'(bus.rsp_valid), 32'd0);
        check("mid rst rsp_id",     32'(bus.rsp_id),    32'd0);
        check("mid rst rsp_result", bus.rsp_result,     32'd0);
        check("mid rst op_count",   32'(op_count),      32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_count = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post rst no rsp", 32'(bus.rsp_valid), 32'd0);
        end
        check("post rst op_count", 32'(op_count), 32'd0);

        run_single(1'b0, 32'hFFFF_FFFF, 32'h1, 4'd0, 32'h0, 1'b1, 1'b0, 1'b0, "add after rst");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
